// File: rtl/crc_frame_engine_if.sv
// Beat-side and result-side signals of the CRC frame engine.
// The master drives beats and observes results; the engine is the slave.
interface crc_frame_engine_if #(
    parameter int CRC_W  = 5,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic [CRC_W-1:0]  crc_init;
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic              in_eof;
    logic [DATA_W-1:0] data_in;
    logic [CRC_W-1:0]  crc_ref;
    logic [CRC_W-1:0]  crc_out;
    logic              crc_valid;
    logic              crc_ok;
    logic [CNT_W-1:0]  frame_len;
    logic              frame_abort;
    logic              sof_err;

    modport master (
        output crc_init, in_valid, in_sof, in_eof, data_in, crc_ref,
        input  in_ready, crc_out, crc_valid, crc_ok, frame_len, frame_abort, sof_err
    );

    modport slave (
        input  crc_init, in_valid, in_sof, in_eof, data_in, crc_ref,
        output in_ready, crc_out, crc_valid, crc_ok, frame_len, frame_abort, sof_err
    );
endinterface

// File: rtl/crc_frame_engine.sv
// Frame-aware parallel CRC: folds DATA_W bits per accepted beat into a CRC_W remainder,
// then publishes CRC, frame length and reference compare through a one-cycle DONE bubble.
module crc_frame_engine #(
    parameter int               CRC_W   = 5,
    parameter int               DATA_W  = 4,
    parameter logic [CRC_W-1:0] POLY    = 5'h09,
    parameter logic [CRC_W-1:0] XOR_OUT = 5'h00,
    parameter int               CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    crc_frame_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CRC_W-1:0]   rem_reg, rem_next;
    logic [CRC_W-1:0]   ref_q_reg, ref_q_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CRC_W-1:0]   crc_out_reg, crc_out_next;
    logic               crc_ok_reg, crc_ok_next;
    logic [CNT_W-1:0]   frame_len_reg, frame_len_next;
    logic               crc_valid_reg, crc_valid_next;
    logic               abort_reg, abort_next;
    logic               sof_err_reg, sof_err_next;

    logic                        in_ready;
    logic                        accept;
    logic [DATA_W:0][CRC_W-1:0]  chain;
    logic [CRC_W-1:0]            final_crc;

    assign in_ready  = (state_reg != DONE);
    assign accept    = bus.in_valid & in_ready;
    assign final_crc = rem_reg ^ XOR_OUT;

    // A SOF beat always restarts from the seed, whether the engine was idle or mid-frame.
    assign chain[0] = bus.in_sof ? bus.crc_init : rem_reg;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_step
            logic fb;
            assign fb = chain[gi][CRC_W-1] ^ bus.data_in[DATA_W-1-gi];
            assign chain[gi+1] = {chain[gi][CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        rem_next       = rem_reg;
        ref_q_next     = ref_q_reg;
        cnt_next       = cnt_reg;
        crc_out_next   = crc_out_reg;
        crc_ok_next    = crc_ok_reg;
        frame_len_next = frame_len_reg;
        crc_valid_next = 1'b0;
        abort_next     = 1'b0;
        sof_err_next   = 1'b0;

        case (state_reg)
            IDLE, RUN: begin
                if (accept) begin
                    if (bus.in_sof) begin
                        rem_next   = chain[DATA_W];
                        cnt_next   = CNT_W'(1);
                        abort_next = (state_reg == RUN);
                        state_next = bus.in_eof ? DONE : RUN;
                        if (bus.in_eof) ref_q_next = bus.crc_ref;
                    end else if (state_reg == RUN) begin
                        rem_next = chain[DATA_W];
                        cnt_next = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
                        if (bus.in_eof) begin
                            ref_q_next = bus.crc_ref;
                            state_next = DONE;
                        end
                    end else begin
                        sof_err_next = 1'b1;
                    end
                end
            end
            DONE: begin
                crc_out_next   = final_crc;
                frame_len_next = cnt_reg;
                crc_ok_next    = (final_crc == ref_q_reg);
                crc_valid_next = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rem_reg       <= '0;
            ref_q_reg     <= '0;
            cnt_reg       <= '0;
            crc_out_reg   <= '0;
            crc_ok_reg    <= 1'b0;
            frame_len_reg <= '0;
            crc_valid_reg <= 1'b0;
            abort_reg     <= 1'b0;
            sof_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rem_reg       <= rem_next;
            ref_q_reg     <= ref_q_next;
            cnt_reg       <= cnt_next;
            crc_out_reg   <= crc_out_next;
            crc_ok_reg    <= crc_ok_next;
            frame_len_reg <= frame_len_next;
            crc_valid_reg <= crc_valid_next;
            abort_reg     <= abort_next;
            sof_err_reg   <= sof_err_next;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.crc_out     = crc_out_reg;
    assign bus.crc_ok      = crc_ok_reg;
    assign bus.frame_len   = frame_len_reg;
    assign bus.crc_valid   = crc_valid_reg;
    assign bus.frame_abort = abort_reg;
    assign bus.sof_err     = sof_err_reg;
endmodule
